// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: field widths and the ID/EX control bundle.
package mips_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 3;

  // EX/MEM/WB control bits carried from decode; all-zero is a bubble.
  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  localparam int unsigned CTRL_W = $bits(id_ex_ctrl_t);

endpackage : mips_pkg

// File: rtl/pipe_field_reg.sv
// Parameterised pipeline field flop: async active-high clear, load enable.
module pipe_field_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Clear on reset, otherwise load when enabled and hold when not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : pipe_field_reg

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Every field loads on a rising clk when hit=1 and holds on a cache-miss
// stall (hit=0). Reset clears every output asynchronously.
// Optional macro ID_EX_FLUSH_EN adds a 'flush' input that loads a bubble
// (all-zero control) regardless of hit while data fields follow hit.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W  = mips_pkg::DATA_W,
  parameter int unsigned REG_W   = mips_pkg::REG_W,
  parameter int unsigned FUNCT_W = mips_pkg::FUNCT_W,
  parameter int unsigned ALUOP_W = mips_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hit,
`ifdef ID_EX_FLUSH_EN
  input  logic               flush,
`endif
  input  logic [DATA_W-1:0]  read_data_1,
  input  logic [DATA_W-1:0]  read_data_2,
  input  logic [DATA_W-1:0]  immeadiate,
  input  logic               reg_dst,
  input  logic               alu_src,
  input  logic               mem_to_reg,
  input  logic               reg_write,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               branch,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  next_pc,
  output logic [DATA_W-1:0]  read_data_1_out,
  output logic [DATA_W-1:0]  read_data_2_out,
  output logic [DATA_W-1:0]  immeadiate_out,
  output logic               reg_dst_out,
  output logic               alu_src_out,
  output logic               mem_to_reg_out,
  output logic               reg_write_out,
  output logic               mem_read_out,
  output logic               mem_write_out,
  output logic               branch_out,
  output logic [ALUOP_W-1:0] alu_op_out,
  output logic [REG_W-1:0]   rt_out,
  output logic [REG_W-1:0]   rd_out,
  output logic [FUNCT_W-1:0] funct_out,
  output logic [DATA_W-1:0]  next_pc_out
);

  import mips_pkg::*;

  id_ex_ctrl_t w_ctrl_in;
  id_ex_ctrl_t w_ctrl_d;
  id_ex_ctrl_t w_ctrl_q;
  logic        w_ctrl_en;

  // Group the decode control bits into the control bundle.
  always_comb begin
    w_ctrl_in            = '0;
    w_ctrl_in.reg_dst    = reg_dst;
    w_ctrl_in.alu_src    = alu_src;
    w_ctrl_in.mem_to_reg = mem_to_reg;
    w_ctrl_in.reg_write  = reg_write;
    w_ctrl_in.mem_read   = mem_read;
    w_ctrl_in.mem_write  = mem_write;
    w_ctrl_in.branch     = branch;
    w_ctrl_in.alu_op     = alu_op;
  end

  // Control load select: flush injects a bubble even while stalled.
  always_comb begin
    w_ctrl_d  = w_ctrl_in;
    w_ctrl_en = hit;
`ifdef ID_EX_FLUSH_EN
    if (flush) begin
      w_ctrl_d  = '0;
      w_ctrl_en = 1'b1;
    end
`endif
  end

  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk (clk), .rst (reset), .i_en (w_ctrl_en), .i_d (w_ctrl_d), .o_q (w_ctrl_q)
  );

  pipe_field_reg #(.W(DATA_W)) u_rd1 (
    .clk (clk), .rst (reset), .i_en (hit), .i_d (read_data_1), .o_q (read_data_1_out)
  );

  pipe_field_reg #(.W(DATA_W)) u_rd2 (
    .clk (clk), .rst (reset), .i_en (hit), .i_d (read_data_2), .o_q (read_data_2_out)
  );

  pipe_field_reg #(.W(DATA_W)) u_imm (
    .clk (clk), .rst (reset), .i_en (hit), .i_d (immeadiate), .o_q (immeadiate_out)
  );

  pipe_field_reg #(.W(DATA_W)) u_npc (
    .clk (clk), .rst (reset), .i_en (hit), .i_d (next_pc), .o_q (next_pc_out)
  );

  pipe_field_reg #(.W(REG_W)) u_rt (
    .clk (clk), .rst (reset), .i_en (hit), .i_d (rt), .o_q (rt_out)
  );

  pipe_field_reg #(.W(REG_W)) u_rd (
    .clk (clk), .rst (reset), .i_en (hit), .i_d (rd), .o_q (rd_out)
  );

  pipe_field_reg #(.W(FUNCT_W)) u_funct (
    .clk (clk), .rst (reset), .i_en (hit), .i_d (funct), .o_q (funct_out)
  );

  assign reg_dst_out    = w_ctrl_q.reg_dst;
  assign alu_src_out    = w_ctrl_q.alu_src;
  assign mem_to_reg_out = w_ctrl_q.mem_to_reg;
  assign reg_write_out  = w_ctrl_q.reg_write;
  assign mem_read_out   = w_ctrl_q.mem_read;
  assign mem_write_out  = w_ctrl_q.mem_write;
  assign branch_out     = w_ctrl_q.branch;
  assign alu_op_out     = w_ctrl_q.alu_op;

endmodule : id_ex_pipe_reg

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg using an expected-value queue.
module tb_id_ex_pipe_reg;

  localparam int unsigned DW     = 32;
  localparam int unsigned RW     = 5;
  localparam int unsigned FW     = 6;
  localparam int unsigned AW     = 3;
  localparam int unsigned CW     = 7 + AW;
  localparam int unsigned VW     = 4 * DW + 2 * RW + FW + CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          hit;
  logic          flush;
  logic [DW-1:0] read_data_1, read_data_2, immeadiate, next_pc;
  logic          reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic [AW-1:0] alu_op;
  logic [RW-1:0] rt, rd;
  logic [FW-1:0] funct;

  logic [DW-1:0] read_data_1_out, read_data_2_out, immeadiate_out, next_pc_out;
  logic          reg_dst_out, alu_src_out, mem_to_reg_out, reg_write_out;
  logic          mem_read_out, mem_write_out, branch_out;
  logic [AW-1:0] alu_op_out;
  logic [RW-1:0] rt_out, rd_out;
  logic [FW-1:0] funct_out;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [VW-1:0] held;
  logic [VW-1:0] exp_q[$];

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk             (clk),
    .reset           (reset),
    .hit             (hit),
`ifdef ID_EX_FLUSH_EN
    .flush           (flush),
`endif
    .read_data_1     (read_data_1),
    .read_data_2     (read_data_2),
    .immeadiate      (immeadiate),
    .reg_dst         (reg_dst),
    .alu_src         (alu_src),
    .mem_to_reg      (mem_to_reg),
    .reg_write       (reg_write),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .branch          (branch),
    .alu_op          (alu_op),
    .rt              (rt),
    .rd              (rd),
    .funct           (funct),
    .next_pc         (next_pc),
    .read_data_1_out (read_data_1_out),
    .read_data_2_out (read_data_2_out),
    .immeadiate_out  (immeadiate_out),
    .reg_dst_out     (reg_dst_out),
    .alu_src_out     (alu_src_out),
    .mem_to_reg_out  (mem_to_reg_out),
    .reg_write_out   (reg_write_out),
    .mem_read_out    (mem_read_out),
    .mem_write_out   (mem_write_out),
    .branch_out      (branch_out),
    .alu_op_out      (alu_op_out),
    .rt_out          (rt_out),
    .rd_out          (rd_out),
    .funct_out       (funct_out),
    .next_pc_out     (next_pc_out)
  );

  // Inputs and outputs flattened in the same field order; control in the low CW bits.
  function automatic logic [VW-1:0] pack_in();
    return {read_data_1, read_data_2, immeadiate, next_pc, rt, rd, funct,
            reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
  endfunction

  function automatic logic [VW-1:0] pack_out();
    return {read_data_1_out, read_data_2_out, immeadiate_out, next_pc_out, rt_out, rd_out,
            funct_out, reg_dst_out, alu_src_out, mem_to_reg_out, reg_write_out,
            mem_read_out, mem_write_out, branch_out, alu_op_out};
  endfunction

  task automatic set_all(input logic [VW-1:0] v);
    {read_data_1, read_data_2, immeadiate, next_pc, rt, rd, funct,
     reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op} = v;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < VW; k += 32) v = (v << 32) | VW'($urandom);
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Predict the next register contents, advance one edge, compare against the queue head.
  task automatic tick(input string tag);
    logic [VW-1:0] e;
    e = hit ? pack_in() : held;
    if (flush) e[CW-1:0] = '0;
    held = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_eq(tag, pack_out(), exp_q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    // Reset with every input nonzero: outputs clear before the first edge.
    reset = 1'b1;
    hit   = 1'b1;
    flush = 1'b0;
    set_all({VW{1'b1}});
    read_data_1 = 32'hDEADBEEF;
    held = '0;
    #1;
    check_eq("reset_async", pack_out(), '0);
    @(posedge clk);
    #1;
    check_eq("reset_hold", pack_out(), '0);
    @(negedge clk);
    reset = 1'b0;

    // Single load: outputs unchanged before the edge, exact after it.
    set_all('0);
    read_data_2 = 32'd1; reg_dst = 1'b1; mem_to_reg = 1'b1; mem_read = 1'b1;
    branch = 1'b1; rt = 5'd1; funct = 6'd1;
    #1;
    check_eq("load_pre_edge", pack_out(), '0);
    tick("load");

    // Stall holds next_pc for three edges, then releases.
    next_pc = 32'h100;
    tick("stall_load");
    hit = 1'b0;
    next_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      tick("stall_hold");
      check_eq("stall_pc", VW'(next_pc_out), VW'(32'h100));
    end
    hit = 1'b1;
    tick("stall_release");
    check_eq("stall_pc_release", VW'(next_pc_out), VW'(32'h104));

    // Back-to-back loads with alu_op stepping 0..7.
    for (int i = 0; i < 8; i++) begin
      set_all(rand_vec());
      alu_op = AW'(i);
      tick("b2b");
      check_eq("b2b_alu_op", VW'(alu_op_out), VW'(i));
    end

    // Reset pulse between edges while stalled.
    set_all(rand_vec());
    rd = 5'd31;
    tick("rd_load");
    hit = 1'b0;
    rd  = 5'd3;
    @(posedge clk);
    #1;
    check_eq("stall_rd", VW'(rd_out), VW'(5'd31));
    #1;
    reset = 1'b1;
    #1;
    check_eq("reset_mid_rd", VW'(rd_out), '0);
    check_eq("reset_mid_all", pack_out(), '0);
    #1;
    reset = 1'b0;
    held  = '0;
    @(negedge clk);
    hit = 1'b1;
    rd  = 5'd9;
    tick("reset_reload");
    check_eq("reset_reload_rd", VW'(rd_out), VW'(5'd9));

`ifdef ID_EX_FLUSH_EN
    // Flush zeroes control but lets data load; while stalled data holds.
    set_all('0);
    flush = 1'b1;
    reg_write = 1'b1;
    read_data_1 = 32'h5;
    tick("flush");
    check_eq("flush_reg_write", VW'(reg_write_out), '0);
    check_eq("flush_rd1", VW'(read_data_1_out), VW'(32'h5));
    hit = 1'b0;
    set_all(rand_vec());
    tick("flush_stall");
    hit = 1'b1;
    flush = 1'b0;
`endif

    // Random mix of loads and stalls.
    for (int i = 0; i < 40; i++) begin
      set_all(rand_vec());
      hit = ($urandom_range(3) != 0);
`ifdef ID_EX_FLUSH_EN
      flush = ($urandom_range(4) == 0);
`endif
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_id_ex_pipe_reg
